// File: rtl/pes_checksum_stream.sv
// Streaming 16-bit one's-complement checksum over DATA_W-bit beats with a held result handshake.
// Optional frame verification output out_ok is enabled by defining PES_CHECKSUM_VERIFY_EN.
module pes_checksum_stream #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_checksum,
    output logic [CNT_W-1:0]  out_beats
`ifdef PES_CHECKSUM_VERIFY_EN
    ,
    output logic              out_ok
`endif
);

    localparam int LANES = DATA_W / 16;

    typedef enum logic {ACCUM, DONE} state_t;

    state_t           state;
    logic [15:0]      acc;
    logic [CNT_W-1:0] beats;

    logic [31:0]      raw;
    logic [31:0]      fold1;
    logic [15:0]      folded;
    logic [CNT_W-1:0] beats_inc;

    // 32-bit raw sum is wide enough for acc plus up to 65535 lanes; two folds then fit 16 bits.
    always_comb begin
        raw = {16'h0000, acc};
        for (int unsigned k = 0; k < LANES; k++) begin
            raw = raw + {16'h0000, in_data[DATA_W-1-16*k -: 16]};
        end
        fold1     = {16'h0000, raw[15:0]} + {16'h0000, raw[31:16]};
        folded    = fold1[15:0] + fold1[31:16];
        beats_inc = (beats == '1) ? beats : beats + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ACCUM;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_checksum <= '0;
            out_beats    <= '0;
            acc          <= '0;
            beats        <= '0;
`ifdef PES_CHECKSUM_VERIFY_EN
            out_ok       <= 1'b0;
`endif
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        if (in_last) begin
                            out_checksum <= ~folded;
                            out_beats    <= beats_inc;
`ifdef PES_CHECKSUM_VERIFY_EN
                            out_ok       <= (folded == 16'hFFFF);
`endif
                            acc          <= '0;
                            beats        <= '0;
                            state        <= DONE;
                            in_ready     <= 1'b0;
                            out_valid    <= 1'b1;
                        end else begin
                            acc   <= folded;
                            beats <= beats_inc;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= ACCUM;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ACCUM;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pes_checksum_stream.sv
// Directed plus randomized bench for pes_checksum_stream against an arithmetic checksum model.
// Verify-mode checks are compiled in when PES_CHECKSUM_VERIFY_EN is defined.
module tb_pes_checksum_stream;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 3;
    localparam int MAXB   = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_checksum;
    logic [CNT_W-1:0]  out_beats;
`ifdef PES_CHECKSUM_VERIFY_EN
    logic              out_ok;
`endif

    int tests = 0;
    int fails = 0;

    logic [31:0] frame [MAXB];

    pes_checksum_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_checksum (out_checksum),
        .out_beats    (out_beats)
`ifdef PES_CHECKSUM_VERIFY_EN
        ,
        .out_ok       (out_ok)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no finish, required finish within 2ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Sum every 16-bit lane of the frame as a plain integer, then wrap carries around.
    function automatic logic [15:0] model_fold(input int n);
        longint unsigned s = 0;
        for (int i = 0; i < n; i++) s += frame[i][31:16] + frame[i][15:0];
        while ((s >> 16) != 0) s = (s & 64'hFFFF) + (s >> 16);
        return s[15:0];
    endfunction

    function automatic logic [31:0] model_beats(input int n);
        return (n > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : n;
    endfunction

    task automatic send_beat(input logic [31:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        check("in_ready_accum", {31'd0, in_ready}, 32'd1);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("beat_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Sends frame[0..n-1]; optionally inserts idle gaps, holds out_ready low for 'hold' cycles.
    task automatic run_frame(input int n, input bit gaps, input bit early, input int hold);
        logic [15:0] f;
        logic [15:0] cks;
        f   = model_fold(n);
        cks = ~f;
        out_ready = early;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) @(negedge clk);
            send_beat(frame[i], i == n - 1);
        end
        check("out_valid_rise", {31'd0, out_valid}, 32'd1);
        check("out_checksum", {16'd0, out_checksum}, {16'd0, cks});
        check("out_beats", {{(32-CNT_W){1'b0}}, out_beats}, model_beats(n));
        check("in_ready_done", {31'd0, in_ready}, 32'd0);
`ifdef PES_CHECKSUM_VERIFY_EN
        check("out_ok", {31'd0, out_ok}, {31'd0, f == 16'hFFFF});
`endif
        if (!early) begin
            for (int c = 0; c < hold; c++) begin
                in_valid = 1'b1;
                in_data  = $urandom;
                in_last  = 1'b1;
                @(negedge clk);
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_checksum", {16'd0, out_checksum}, {16'd0, cks});
                check("hold_beats", {{(32-CNT_W){1'b0}}, out_beats}, model_beats(n));
                check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            end
            in_valid  = 1'b0;
            in_last   = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        check("out_valid_fall", {31'd0, out_valid}, 32'd0);
        check("in_ready_back", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_checksum", {16'd0, out_checksum}, 32'd0);
        check("rst_beats", {{(32-CNT_W){1'b0}}, out_beats}, 32'd0);
`ifdef PES_CHECKSUM_VERIFY_EN
        check("rst_ok", {31'd0, out_ok}, 32'd0);
`endif
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        @(negedge clk);

        frame[0] = 32'h9D2DC3D5;
        run_frame(1, 1'b0, 1'b0, 0);
        frame[1] = 32'h00010002;
        run_frame(2, 1'b0, 1'b0, 0);
        frame[0] = 32'hFFFFFFFF;
        run_frame(1, 1'b0, 1'b0, 0);
        frame[0] = 32'h0000FFFF;
        run_frame(1, 1'b0, 1'b1, 0);
        frame[0] = 32'h00000000;
        run_frame(1, 1'b0, 1'b0, 0);

        // Backpressure with junk beats offered, then a clean frame proves none were absorbed.
        frame[0] = 32'h12345678; frame[1] = 32'h9ABCDEF0; frame[2] = 32'h0F0F0F0F;
        run_frame(3, 1'b0, 1'b0, 5);
        frame[0] = 32'h00010002;
        run_frame(1, 1'b0, 1'b0, 0);

        // Saturating beat count (CNT_W=3 saturates at 7).
        for (int i = 0; i < 10; i++) frame[i] = $urandom;
        run_frame(10, 1'b0, 1'b0, 1);

`ifdef PES_CHECKSUM_VERIFY_EN
        frame[0] = 32'h9D2DC3D5; frame[1] = 32'h00009EFC;
        run_frame(2, 1'b0, 1'b0, 0);
        frame[1] = 32'h00009EFD;
        run_frame(2, 1'b0, 1'b0, 0);
`endif

        // Reset mid-frame discards the partial sum.
        in_valid = 1'b1; in_data = 32'h9D2DC3D5; in_last = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame[0] = 32'h00010002;
        run_frame(1, 1'b0, 1'b0, 0);

        // Reset while holding a result in DONE.
        in_valid = 1'b1; in_data = 32'hABCD1234; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        check("done_before_rst", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 25; t++) begin
            int n;
            n = $urandom_range(1, 9);
            for (int i = 0; i < n; i++) frame[i] = $urandom;
            if ($urandom_range(0, 3) == 0) frame[0] = 32'hFFFFFFFF;
            run_frame(n, 1'b1, bit'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pes_checksum_stream.md
# pes_checksum_stream

Streaming, parametrised successor to the single-word 16-bit one's-complement checksum. It accepts a frame of DATA_W-bit beats over a valid/ready handshake and accumulates all 16-bit lanes with end-around carry. On the last beat it presents the inverted 16-bit checksum and the frame's beat count on a held output handshake. It sits between a packet source and the header-insertion or verification logic in the PES datapath.

## Interface
- DATA_W, 32, beat width in bits; a multiple of 16, at least 16; LANES = DATA_W/16
- CNT_W, 16, width of the beat counter; saturates at all-ones
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  beat present
- in_ready  output  1  block can accept a beat
- in_data  input  DATA_W  beat; lane k = in_data[DATA_W-1-16k -: 16]
- in_last  input  1  final beat of frame (qualified by in_valid)
- out_valid  output  1  checksum result valid
- out_ready  input  1  consumer accepts result
- out_checksum  output  16  ~(one's-complement sum of all lanes in frame)
- out_beats  output  CNT_W  number of beats in the frame (saturating)
- out_ok  output  1  present only with PES_CHECKSUM_VERIFY_EN (see Configuration)

## Operation
- FSM with two states:
  - ACCUM: in_ready=1.
  - DONE: in_ready=0, out_valid=1.
- A beat is accepted when in_valid && in_ready. On acceptance:
  - raw = acc + Σ lanes.
  - Fold twice: x = x[15:0] + (x >> 16). acc ← 16-bit result.
  - beats ← beats+1, saturating at 2^CNT_W−1.
- Accepted beat with in_last=1:
  - Registers out_checksum = ~folded.
  - Registers out_beats = beats+1 (saturating).
  - Clears acc and beats to 0 and moves to DONE.
- A single-beat frame (in_last on the first beat) is legal.
- DONE: when out_ready=1, go to ACCUM next cycle. Outputs hold stable until that handshake.
- in_data and in_last are ignored while in_ready=0.
- Negative zero: a folded sum of 0xFFFF yields checksum 0x0000, with no remapping.

## Timing
- Reset values (asynchronous):
  - FSM in ACCUM; in_ready=1, out_valid=0.
  - out_checksum=0x0000, out_beats=0, out_ok=0.
  - acc=0, beats=0.
- Throughput: one beat per cycle within a frame.
- Latency: last beat accepted on edge N → out_valid=1 after edge N.
- No new beat is accepted until the cycle after the out handshake. Minimum frame-to-frame spacing is one bubble cycle.
- in_ready depends only on state, never combinationally on in_valid or out_ready.
- out_ready already high when out_valid rises: the handshake completes on the first DONE cycle, and out_valid is 1 for exactly one cycle.
- Reset asserted mid-frame or in DONE: the partial sum and the held result are discarded, and outputs immediately return to reset values.

## Configuration
- PES_CHECKSUM_VERIFY_EN defined:
  - Adds port out_ok, registered with out_checksum.
  - out_ok = 1 when the folded frame sum equals 0xFFFF, i.e. the frame, including its embedded checksum, verifies.
- Undefined: no out_ok port and no comparator. All other behaviour is identical.

## Test plan
- Single beat, DATA_W=32, in_data=0x9D2DC3D5, in_last=1 → next cycle: out_valid=1, out_checksum=0x9EFC, out_beats=1.
- Two beats, 0x9D2DC3D5 then 0x00010002 (last) → out_checksum=0x9EF9, out_beats=2. in_ready=1 on both cycles.
- Carry fold: single beat 0xFFFFFFFF → out_checksum=0x0000. Beat 0x0000FFFF → out_checksum=0x0000.
- Backpressure: hold out_ready=0 for 5 cycles after the result.
  - out_valid, out_checksum and out_beats stay stable.
  - in_ready=0 and a driven in_valid beat is not absorbed.
  - On out_ready=1, in_ready returns next cycle.
- Verify mode (macro defined): frame 0x9D2DC3D5, 0x00009EFC (last) → out_checksum=0x0000, out_ok=1. Changing the second beat to 0x00009EFD → out_ok=0.
- Reset mid-frame: accept 0x9D2DC3D5 (not last), pulse rst_n low, then send 0x00010002 as a single-beat frame → out_checksum=0xFFFC, out_beats=1.
